// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key-code mapping for the keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam int KEY_W    = 5;

  localparam logic [KEY_W-1:0] KEY_NONE = 5'd0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_e;

  // Row r, column c -> code r*4 + c + 1 (key 1 = row0/col0, key 20 = row4/col3).
  function automatic logic [KEY_W-1:0] key_code(input logic [2:0] r, input logic [1:0] c);
    return {r, 2'b00} + {3'b000, c} + 5'd1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: accepts a press after DEBOUNCE_FRAMES identical
// non-zero frames and a release after DEBOUNCE_FRAMES empty frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_done,
  input  logic [KEY_W-1:0] i_frame_code,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  assign cnt_inc = cnt_q + CNT_ONE;

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      code_q  <= KEY_NONE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; only a frame_done cycle can move the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (i_frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (i_frame_code != KEY_NONE) begin
            cand_d = i_frame_code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = PRESSED;
              code_d  = i_frame_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (i_frame_code == KEY_NONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (i_frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            // A different key restarts the count with the new candidate.
            cand_d = i_frame_code;
            cnt_d  = CNT_ONE;
          end
        end
        PRESSED: begin
          // Non-zero frames (same or other key) are ignored: no rollover.
          if (i_frame_code == KEY_NONE) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (i_frame_code == KEY_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            // Release glitch: back to held without a new pulse.
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_key_code  = code_q;
  assign o_key_valid = valid_q;
  assign o_key_held  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column scan, row synchronisation and per-frame key decode for a 4x5 matrix;
// debouncing is delegated to keypad_debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [NUM_COLS-1:0] o_key_col,
  input  logic [NUM_ROWS-1:0] i_key_row,
  output logic [KEY_W-1:0]    o_key_code,
  output logic                o_key_valid,
  output logic                o_key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta_q;
  logic [NUM_ROWS-1:0] row_sync_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          hits_q, hits_d;        // saturating hit count: 0, 1, 2 = many
  logic [KEY_W-1:0]    hit_code_q, hit_code_d;
  logic                frame_done_q, frame_done_d;
  logic [KEY_W-1:0]    frame_code_q, frame_code_d;

  logic                sample;
  logic [1:0]          col_hits;
  logic [KEY_W-1:0]    col_code;
  logic [KEY_W-1:0]    code_acc;
  logic [2:0]          hit_sum;
  logic [1:0]          hits_sat;
  logic [KEY_W-1:0]    row_code [NUM_ROWS];

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
    end else begin
      row_meta_q <= i_key_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Code each row would produce in the column currently being driven.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row_code
    assign row_code[gi] = row_sync_q[gi] ? key_code(3'(gi), col_idx_q) : KEY_NONE;
  end

  // Per-column decode: number of rows hit and the code of a lone hit.
  always_comb begin
    col_hits = 2'd0;
    col_code = KEY_NONE;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_sync_q[r] && (col_hits != 2'd2)) begin
        col_hits = col_hits + 2'd1;
      end
      col_code = col_code | row_code[r];
    end
  end

  // Scan timing and frame accumulation; rows are sampled at the last count
  // of each column so the synchroniser has settled on the new drive.
  always_comb begin
    sample       = (div_q == DIV_LAST);
    div_d        = sample ? '0 : div_q + DIV_W'(1);
    col_idx_d    = sample ? col_idx_q + 2'd1 : col_idx_q;
    hits_d       = hits_q;
    hit_code_d   = hit_code_q;
    frame_done_d = 1'b0;
    frame_code_d = frame_code_q;

    hit_sum  = {1'b0, hits_q} + {1'b0, col_hits};
    hits_sat = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_acc = (col_hits == 2'd1) ? col_code : hit_code_q;

    if (sample) begin
      if (col_idx_q == 2'(NUM_COLS - 1)) begin
        frame_done_d = 1'b1;
        frame_code_d = (hits_sat == 2'd1) ? code_acc : KEY_NONE;
        hits_d       = 2'd0;
        hit_code_d   = KEY_NONE;
      end else begin
        hits_d     = hits_sat;
        hit_code_d = code_acc;
      end
    end
  end

  // Scan and accumulator registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      hits_q       <= 2'd0;
      hit_code_q   <= KEY_NONE;
      frame_done_q <= 1'b0;
      frame_code_q <= KEY_NONE;
    end else begin
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      hits_q       <= hits_d;
      hit_code_q   <= hit_code_d;
      frame_done_q <= frame_done_d;
      frame_code_q <= frame_code_d;
    end
  end

  assign o_key_col = 4'b0001 << col_idx_q;

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_done(frame_done_q),
    .i_frame_code(frame_code_q),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Host-side end of the 4-column x 5-row key matrix interface. It drives the column scan, samples the row returns, and decodes each frame to a key code. It debounces presses and releases and issues one press event per keystroke to the FFT calculator's input logic. It is the counterpart of the matrix model that turns a key value plus the column drive into row levels.

Parameters:
SCAN_DIV, 10000, cycles each column is driven (1 ms at 10 MHz); minimum 4
DEBOUNCE_FRAMES, 3, consecutive identical full-scan frames required to accept a press or a release; minimum 1

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
o_key_col  out  4  one-hot active-high column drive
i_key_row  in  5  row returns, active-high; asynchronous to i_clk
o_key_code  out  5  accepted key code 1..20; 0 = none since reset
o_key_valid  out  1  one-cycle pulse when a new press is accepted
o_key_held  out  1  level, high from the press-accept cycle until the release is accepted

Behaviour:
- Reset (sync): o_key_col=4'b0001; scan counter=0; column index=0; state=IDLE; o_key_code=0; o_key_valid=0; o_key_held=0; debounce count=0; frame accumulator cleared.
- Row synchroniser: 2-flop synchroniser on i_key_row; all logic uses the synchronised value.
- Scan:
  - Counter runs 0..SCAN_DIV-1 per column.
  - Rows are sampled at count SCAN_DIV-1, which leaves settle time for the synchroniser.
  - The column then advances 0->1->2->3->0; o_key_col rotates left and wraps.
- Key code: row r (0..4) with column c (0..3) gives code = r*4 + c + 1. Key 1 = row0/col0; key 20 = row4/col3.
- Frame code:
  - Every sample is accumulated over the 4 columns.
  - If exactly one row/column hit occurred in the frame, frame code = that code.
  - If there were zero hits, or two or more (ghost or multi-key), frame code = 0.
  - frame_done pulses in the cycle after column 3 is sampled.
  - The accumulator clears for the next frame.
- FSM (evaluated on frame_done only):
  - IDLE:
    - fc != 0: cand = fc, cnt = 1, go to DEB_PRESS.
    - If DEBOUNCE_FRAMES = 1, go straight to PRESSED.
  - DEB_PRESS:
    - fc == cand: cnt++; when cnt reaches DEBOUNCE_FRAMES, go to PRESSED.
    - fc != cand and fc != 0: restart, cand = fc, cnt = 1.
    - fc == 0: go to IDLE.
  - Press accept:
    - o_key_code <= cand, o_key_valid = 1 for exactly one cycle, o_key_held <= 1.
    - All of these occur in the cycle after the accepting frame_done.
  - PRESSED:
    - fc == 0: cnt = 1, go to DEB_REL.
    - Any nonzero fc, including a different key, is ignored. There is no rollover; a new key requires a full release first.
  - DEB_REL:
    - fc == 0: cnt++; at DEBOUNCE_FRAMES, o_key_held <= 0 and go to IDLE.
    - fc != 0: go back to PRESSED with no new pulse.
  - o_key_code keeps its last accepted value after release.
- Press latency: DEBOUNCE_FRAMES complete frames plus the partial frame plus 1 cycle. Worst case (DEBOUNCE_FRAMES+1)*4*SCAN_DIV + 3 cycles from the row input changing.
- Reset mid-operation: all state returns to reset values in the next cycle. No pending pulse is emitted.

Decomposition:
- Package keypad_pkg: NUM_COLS=4, NUM_ROWS=5, KEY_W=5, KEY_NONE=5'd0, the FSM state enum (IDLE, DEB_PRESS, PRESSED, DEB_REL), and the code-mapping function (r, c) -> code.
- Sub-module keypad_debounce: the FSM plus its counter. Inputs are frame_done and frame code; outputs are code, valid and held.
- The scan, synchroniser and frame accumulation stay in keypad_scanner.

Test Plan:
Benches use SCAN_DIV=8 and DEBOUNCE_FRAMES=3 (32-cycle frame). The matrix model sits in the loop.
- Hold key 7 (row1/col2) for 10 frames, then release -> exactly one o_key_valid pulse. o_key_code=7 by frame 4. o_key_held falls 3 frames after release. o_key_col cycles 1,2,4,8.
- Key sequence 1, 2, 3, 4, 5, 6, 7, 8, 9, each held 6 frames with a 6-frame gap -> 9 pulses with codes 1..9 in order.
- Hold key 20 for 2 frames only -> no pulse; o_key_code stays 0 after reset.
- Hold key 4, then while held add key 15 -> frames with two hits decode to 0 and send the FSM to DEB_REL. Dropping key 15 returns it to PRESSED with no new pulse. After a full release, pressing 15 alone -> pulse with code 15.
- Release glitch: key 12 held, one zero frame, then key 12 again -> o_key_held stays 1 and no second pulse.
- Assert i_rst during DEB_PRESS, at count 2 -> all outputs 0 the next cycle and o_key_col=0001. Hold the key 3 more frames after reset -> one pulse.
